mult_norm_round: RTL and testbench
==================================

Name: mult_norm_round

Overview:
- Downstream stage of the 24x24 sequential shift-add mantissa multiplier datapath.
- Consumes the 48-bit product ({P,A} result bus) plus a pre-computed biased exponent sum.
- Normalises iteratively (one left shift per cycle) and rounds to nearest-even.
- Flags zero/overflow/underflow; emits a packed-ready mantissa/exponent pair over a valid/ready handshake.

Parameters:
- MANT_W, 24: mantissa width including hidden bit; product width is 2*MANT_W.
- EXP_W, 8: biased exponent field width; internal exponent is signed EXP_W+2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product/exponent present.
- in_ready  out  1  block can accept; high only in IDLE.
- prod_in  in  2*MANT_W  raw mantissa product.
- exp_in  in  EXP_W+2  signed biased exponent sum (bias already removed once upstream).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- mant_out  out  MANT_W  normalised, rounded mantissa (hidden bit at MSB).
- exp_out  out  EXP_W  final biased exponent.
- zero  out  1  result is zero.
- overflow  out  1  exponent overflow; mant_out=0, exp_out=all ones.
- underflow  out  1  exponent underflow, flushed to zero; mant_out=0, exp_out=0.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; mant_out=0; exp_out=0; all flags 0; internal P/E regs cleared. Reset mid-operation aborts to IDLE with no output.
- FSM states and transitions:
  - IDLE: on in_valid&in_ready, latch P<=prod_in, E<=exp_in, go NORM.
  - NORM, one decision per cycle:
    - P==0: zero=1, mant=0, exp=0, go DONE.
    - P[2M-1]=1: mant=P[2M-1:M], guard=P[M-1], sticky=|P[M-2:0], E<=E+1, go ROUND.
    - else P[2M-2]=1: mant=P[2M-2:M-1], guard=P[M-2], sticky=|P[M-3:0], go ROUND.
    - else: P<=P<<1, E<=E-1, stay NORM.
  - ROUND:
    - inc = guard & (sticky | mant[0]); sum = mant+inc (MANT_W+1 bits).
    - On carry out: mant=1<<(MANT_W-1), E<=E+1.
    - Range check on post-round E: E >= 2^EXP_W-1 gives overflow; E <= 0 gives underflow.
    - Go DONE.
  - DONE: out_valid=1; outputs and flags stable. On out_ready go IDLE and drop out_valid the next cycle.
- Latency: accept edge k; out_valid high from edge k+3 for an already-normalised product. Each extra leading zero below bit 2M-2 adds one cycle; worst case 2M-2 NORM cycles.
- Simultaneous events:
  - No new accept while busy.
  - DONE with out_ready high at the same edge returns to IDLE; the next accept is possible one cycle later (no same-cycle turnaround).
  - Outputs keep their last values in IDLE until the next result is loaded.
- Flags are mutually exclusive.

Optional Feature:
- Macro MULT_NORM_ROUND_EN.
- Defined: round-to-nearest-even as above.
- Undefined:
  - ROUND performs truncation (inc=0, round toward zero); guard/sticky logic is removed.
  - Latency is unchanged.
  - Overflow/underflow checks are still applied.

Decomposition:
- Shared package mult_pkg: FSM state enum (IDLE, NORM, ROUND, DONE), MANT_W/EXP_W defaults, derived PROD_W=2*MANT_W, EXP_MAX constant.
- One combinational sub-module round_rne: mant, guard, sticky in; rounded mant and carry out. Instantiated only under MULT_NORM_ROUND_EN.

Test Plan:
- prod_in=48'h400000_000000, exp_in=127 -> mant_out=24'h800000, exp_out=127, flags 0, out_valid exactly 3 cycles after accept edge.
- prod_in=48'hFFFFFF_C00000, exp_in=127 -> rounding carry: mant_out=24'h800000, exp_out=129. Without macro: mant_out=24'hFFFFFF, exp_out=128.
- Ties: prod_in=48'h400000_C00000 -> mant_out=24'h800002; prod_in=48'h400000_400000 -> mant_out=24'h800000; both exp_out=exp_in.
- Unnormalised: prod_in=48'h000000_800000, exp_in=150 -> 23 NORM shifts, mant_out=24'h800000, exp_out=127, out_valid at k+26. prod_in=0 -> zero=1, mant_out=0, exp_out=0.
- Range: prod_in=48'hFFFFFF_C00000, exp_in=253 -> overflow=1, exp_out=8'hFF, mant_out=0. prod_in=48'h400000_000000, exp_in=0 -> underflow=1, outputs 0.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - Assert rst during NORM of the 23-shift case -> immediate IDLE, out_valid=0, in_ready=1 after release.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states, default widths and exponent limit for mult_norm_round
package mult_pkg;
  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF = 8;
  localparam int PROD_W = 2 * MANT_W_DEF;
  localparam int EXP_MAX = (1 << EXP_W_DEF) - 1;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;
endpackage

// File: rtl/round_rne.sv
// round_rne: round-to-nearest-even increment of a truncated mantissa
// Ports: mant/guard/sticky in; mant_rnd (renormalised on carry) and carry out.
module round_rne #(
  parameter int W = 24
) (
  input  logic [W-1:0] mant,
  input  logic         guard,
  input  logic         sticky,
  output logic [W-1:0] mant_rnd,
  output logic         carry
);
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, mant} + (W+1)'(guard & (sticky | mant[0]));
    carry = sum[W];
    mant_rnd = carry ? {1'b1, {(W-1){1'b0}}} : sum[W-1:0];
  end
endmodule

// File: rtl/mult_norm_round.sv
// mult_norm_round: iterative normalise + round stage after the mantissa multiplier
// Ports: clk, rst (async, active high); in_valid/in_ready with prod_in, exp_in;
// out_valid/out_ready with mant_out, exp_out, zero, overflow, underflow.
// MULT_NORM_ROUND_EN defined: round to nearest even; undefined: truncate.
module mult_norm_round import mult_pkg::*; #(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*MANT_W-1:0] prod_in,
  input  logic [EXP_W+1:0]    exp_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W-1:0]   mant_out,
  output logic [EXP_W-1:0]    exp_out,
  output logic                zero,
  output logic                overflow,
  output logic                underflow
);
  localparam int PW = 2 * MANT_W;
  localparam logic signed [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] E_TOP = (EXP_W+2)'((1 << EXP_W) - 1);
  state_e state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic signed [EXP_W+1:0] e_q, e_d, e_post;
  logic [MANT_W-1:0] m_q, m_d, m_rnd, mant_out_q, mant_out_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic carry, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic zero_q, zero_d, overflow_q, overflow_d, underflow_q, underflow_d;
`ifdef MULT_NORM_ROUND_EN
  logic g_q, g_d, s_q, s_d;
  round_rne #(.W(MANT_W)) u_rnd (.mant(m_q), .guard(g_q), .sticky(s_q), .mant_rnd(m_rnd), .carry(carry));
`else
  assign m_rnd = m_q;
  assign carry = 1'b0;
`endif
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign mant_out = mant_out_q;
  assign exp_out = exp_out_q;
  assign zero = zero_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    e_d = e_q;
    m_d = m_q;
`ifdef MULT_NORM_ROUND_EN
    g_d = g_q;
    s_d = s_q;
`endif
    mant_out_d = mant_out_q;
    exp_out_d = exp_out_q;
    zero_d = zero_q;
    overflow_d = overflow_q;
    underflow_d = underflow_q;
    out_valid_d = out_valid_q;
    e_post = e_q + $signed({{(EXP_W+1){1'b0}}, carry});
    case (state_q)
      IDLE: if (in_valid) begin
        p_d = prod_in;
        e_d = exp_in;
        state_d = NORM;
      end
      NORM: if (p_q == '0) begin
        mant_out_d = '0;
        exp_out_d = '0;
        zero_d = 1'b1;
        overflow_d = 1'b0;
        underflow_d = 1'b0;
        state_d = DONE;
      end else if (p_q[PW-1]) begin
        m_d = p_q[PW-1:MANT_W];
`ifdef MULT_NORM_ROUND_EN
        g_d = p_q[MANT_W-1];
        s_d = |p_q[MANT_W-2:0];
`endif
        e_d = e_q + E_ONE;
        state_d = ROUND;
      end else if (p_q[PW-2]) begin
        m_d = p_q[PW-2:MANT_W-1];
`ifdef MULT_NORM_ROUND_EN
        g_d = p_q[MANT_W-2];
        s_d = |p_q[MANT_W-3:0];
`endif
        state_d = ROUND;
      end else begin
        p_d = p_q << 1;
        e_d = e_q - E_ONE;
      end
      ROUND: begin
        e_d = e_post;
        overflow_d = e_post >= E_TOP;
        underflow_d = e_post[EXP_W+1] || e_post == '0;
        zero_d = 1'b0;
        mant_out_d = (overflow_d || underflow_d) ? '0 : m_rnd;
        exp_out_d = overflow_d ? '1 : underflow_d ? '0 : e_post[EXP_W-1:0];
        state_d = DONE;
      end
      DONE: begin
        out_valid_d = !(out_valid_q && out_ready);
        state_d = (out_valid_q && out_ready) ? IDLE : DONE;
      end
    endcase
    in_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q <= '0;
      e_q <= '0;
      m_q <= '0;
`ifdef MULT_NORM_ROUND_EN
      g_q <= 1'b0;
      s_q <= 1'b0;
`endif
      mant_out_q <= '0;
      exp_out_q <= '0;
      zero_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      e_q <= e_d;
      m_q <= m_d;
`ifdef MULT_NORM_ROUND_EN
      g_q <= g_d;
      s_q <= s_d;
`endif
      mant_out_q <= mant_out_d;
      exp_out_q <= exp_out_d;
      zero_q <= zero_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q <= in_ready_d;
    end
  end
endmodule

// File: tb/tb_mult_norm_round.sv
// tb_mult_norm_round: directed and random vectors against a value-level reference model
module tb_mult_norm_round;
  import mult_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, zero, overflow, underflow;
  logic [47:0] prod_in = '0;
  logic [9:0] exp_in = '0;
  logic [23:0] mant_out;
  logic [7:0] exp_out;
  int n_chk = 0, n_bad = 0;
  always #5 clk = ~clk;
  mult_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .prod_in(prod_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .zero(zero), .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic model(input logic [47:0] p, input int e_in, output logic [23:0] m, output logic [7:0] eo,
                       output logic z, output logic ov, output logic un, output int lat);
    longint x, rem, half;
    int msb, sh, e;
    logic [24:0] mm;
    msb = -1; e = e_in; z = 0; ov = 0; un = 0; m = '0; eo = '0; lat = 2;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    if (msb < 0) begin
      z = 1;
      return;
    end
    x = longint'(p);
    if (msb == 47) begin
      sh = 24; e++; lat = 3;
    end else begin
      x = x << (46 - msb); sh = 23; e -= 46 - msb; lat = 3 + 46 - msb;
    end
    mm = 25'(x >> sh);
    rem = x & ((64'sd1 << sh) - 1);
    half = 64'sd1 << (sh - 1);
`ifdef MULT_NORM_ROUND_EN
    if (rem > half || (rem == half && mm[0])) mm++;
`endif
    if (mm[24]) begin
      mm = 25'h800000; e++;
    end
    ov = e >= EXP_MAX;
    un = !ov && e <= 0;
    m = (ov || un) ? 24'h0 : mm[23:0];
    eo = ov ? 8'hFF : un ? 8'h00 : 8'(e);
  endtask
  task automatic run(input logic [47:0] p, input int e, input int hold);
    logic [23:0] m;
    logic [7:0] eo;
    logic z, ov, un;
    int lat, cnt;
    model(p, e, m, eo, z, ov, un, lat);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    prod_in = p; exp_in = 10'(e); in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1 cnt++;
    end
    chk("latency", 64'(cnt), 64'(lat));
    chk("mant_out", 64'(mant_out), 64'(m));
    chk("exp_out", 64'(exp_out), 64'(eo));
    chk("flags", 64'({zero, overflow, underflow}), 64'({z, ov, un}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_state", 64'({out_valid, in_ready, mant_out, exp_out}), 64'({2'b10, m, eo}));
    end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("drop_valid", 64'({out_valid, in_ready}), 64'b01);
    chk("keep_mant", 64'(mant_out), 64'(m));
  endtask
  initial begin
    logic [47:0] dp [9] = '{48'h400000_000000, 48'hFFFFFF_C00000, 48'h400000_C00000, 48'h400000_400000,
                            48'h000000_800000, 48'h0, 48'hFFFFFF_C00000, 48'hFFFFFF_C00000, 48'h400000_000000};
    int de [9] = '{127, 127, 127, 127, 150, 127, 253, 254, 0};
    logic [47:0] p;
    int seen;
    #12 chk("rst_state", 64'({in_ready, out_valid, mant_out, exp_out, zero, overflow, underflow}), 64'({2'b10, 35'd0}));
    @(negedge clk) rst = 0;
    for (int i = 0; i < 9; i++) run(dp[i], de[i], i == 0 ? 5 : 0);
    prod_in = 48'h000000_800000; exp_in = 10'd150; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1 chk("rst_abort", 64'({out_valid, in_ready}), 64'b01);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1 if (out_valid) seen++;
    end
    chk("rst_no_out", 64'(seen), 64'd0);
    for (int i = 0; i < 60; i++) begin
      p = {16'($urandom), $urandom};
      p = ($urandom_range(0, 9) == 0) ? 48'h0 : p >> $urandom_range(0, 47);
      run(p, int'($urandom_range(0, 380)) - 60, int'($urandom_range(0, 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
